// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: the memory-wait
// FSM state type and the default widths used by the top and its counters.
package hazard_ctrl_pkg;

    // Default register-index width (16 architectural registers).
    localparam int DEF_REG_W       = 4;
    // Default statistics counter width.
    localparam int DEF_CNT_W       = 16;
    // Default number of MEM_WAIT cycles tolerated before flagging an error.
    localparam int DEF_MEM_TIMEOUT = 64;

    // RUN: pipeline flows normally, MEM_WAIT: a MEM-stage access is outstanding.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    // Width needed to hold a wait count in the range 0 .. timeout-1.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear. Holds at all-ones
// instead of wrapping so a long-running statistic never reads as small.
module sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_full;

    assign w_full  = (r_count == {CNT_W{1'b1}});
    assign o_count = r_count;

    // Count qualifying events; clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registered state is written with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_full) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. Decides each cycle, combinationally, whether
// the front end must freeze or flush because of an outstanding memory
// access, a taken branch resolved in EXE, or a data hazard against an
// in-flight writer. A two-state FSM tracks memory waits and enforces a
// timeout; three saturating counters keep event statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W       = DEF_REG_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    // ID-stage sources
    input  logic [REG_W-1:0] src1_ID,
    input  logic [REG_W-1:0] src2_ID,
    input  logic             use_src1_ID,
    input  logic             two_src_ID,
    // in-flight writers
    input  logic [REG_W-1:0] dest_EXE,
    input  logic [REG_W-1:0] dest_MEM,
    input  logic             wb_en_EXE,
    input  logic             wb_en_MEM,
    input  logic             mem_r_en_EXE,
    input  logic             forward_en,
    // control flow and memory
    input  logic             branch_taken_EXE,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    input  logic             clr_stats,
    // pipeline control
    output logic             freeze_IF,
    output logic             flush_IF,
    output logic             flush_ID,
    output logic             freeze_all,
    // status
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam int               WAIT_W    = wait_cnt_width(MEM_TIMEOUT);
    // Value of the wait counter during the last MEM_WAIT cycle allowed; if
    // memory is still not ready then, the wait is abandoned.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;

    logic w_match_exe;
    logic w_match_mem;
    logic w_hazard;
    logic w_in_wait;
    logic w_timeout;
    logic w_mem_stall;
    logic w_branch_flush;
    logic w_hazard_only;

    // ------------------------------------------------------------------
    // Data-hazard detection
    // ------------------------------------------------------------------
    assign w_match_exe = (use_src1_ID && (src1_ID == dest_EXE)) ||
                         (two_src_ID  && (src2_ID == dest_EXE));
    assign w_match_mem = (use_src1_ID && (src1_ID == dest_MEM)) ||
                         (two_src_ID  && (src2_ID == dest_MEM));

    // With forwarding, only a load in EXE cannot be bypassed in time;
    // without it, any pending writer to a needed source must drain first.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch
        // is inferred on any path through the branches below.
        w_hazard = 1'b0;
        if (forward_en) begin
            w_hazard = mem_r_en_EXE && wb_en_EXE && w_match_exe;
        end else begin
            w_hazard = (wb_en_EXE && w_match_exe) || (wb_en_MEM && w_match_mem);
        end
    end

    // ------------------------------------------------------------------
    // Memory stall and timeout
    // ------------------------------------------------------------------
    assign w_in_wait = (r_state == MEM_WAIT);

    // On the final permitted wait cycle with memory still busy, the freeze
    // is dropped in that same cycle and the FSM heads back to RUN.
    assign w_timeout = w_in_wait && !mem_ready && (r_wait_cnt == WAIT_LAST);

    // An access completing in the same cycle it is issued never stalls.
    assign w_mem_stall = w_in_wait ? (!mem_ready && !w_timeout)
                                   : (mem_req_MEM && !mem_ready);

    // A taken branch is ignored while memory stalls; it sits frozen in EXE
    // and takes effect on the first unfrozen cycle.
    assign w_branch_flush = branch_taken_EXE && !w_mem_stall;
    assign w_hazard_only  = w_hazard && !w_mem_stall && !branch_taken_EXE;

    // ------------------------------------------------------------------
    // Pipeline control outputs (priority: mem stall > branch > hazard)
    // ------------------------------------------------------------------

    // Resolve the three stall/flush causes into the four control lines.
    always_comb begin
        freeze_IF  = 1'b0;
        flush_IF   = 1'b0;
        flush_ID   = 1'b0;
        freeze_all = 1'b0;
        if (w_mem_stall) begin
            freeze_all = 1'b1;
            freeze_IF  = 1'b1;
        end else if (w_branch_flush) begin
            // IF/ID honours freeze over flush, so freeze_IF must stay low.
            flush_IF = 1'b1;
            flush_ID = 1'b1;
        end else if (w_hazard_only) begin
            freeze_IF = 1'b1;
            flush_ID  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM, wait counter and sticky error flag
    // ------------------------------------------------------------------

    // Track outstanding memory accesses and raise mem_err on timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_wait_cnt <= '0;
                    if (mem_req_MEM && !mem_ready) begin
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready || w_timeout) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase

            // Clearing the statistics also clears the error, even if a
            // timeout fires in the same cycle.
            if (clr_stats) begin
                r_mem_err <= 1'b0;
            end else if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_hazard_only),
        .i_clr   (clr_stats),
        .o_count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_branch_flush),
        .i_clr   (clr_stats),
        .o_count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_mem_stall),
        .i_clr   (clr_stats),
        .o_count (memwait_cnt)
    );

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic.
// A behavioural model predicts every cycle's outputs into a queue; an
// independent monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

    localparam int REG_W = 4;
    localparam int CNT_W = 4;
    localparam int TO    = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
    logic             use_src1_ID, two_src_ID, wb_en_EXE, wb_en_MEM;
    logic             mem_r_en_EXE, forward_en, branch_taken_EXE;
    logic             mem_req_MEM, mem_ready, clr_stats;
    logic             freeze_IF, flush_IF, flush_ID, freeze_all, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .src1_ID          (src1_ID),
        .src2_ID          (src2_ID),
        .use_src1_ID      (use_src1_ID),
        .two_src_ID       (two_src_ID),
        .dest_EXE         (dest_EXE),
        .dest_MEM         (dest_MEM),
        .wb_en_EXE        (wb_en_EXE),
        .wb_en_MEM        (wb_en_MEM),
        .mem_r_en_EXE     (mem_r_en_EXE),
        .forward_en       (forward_en),
        .branch_taken_EXE (branch_taken_EXE),
        .mem_req_MEM      (mem_req_MEM),
        .mem_ready        (mem_ready),
        .clr_stats        (clr_stats),
        .freeze_IF        (freeze_IF),
        .flush_IF         (flush_IF),
        .flush_ID         (flush_ID),
        .freeze_all       (freeze_all),
        .mem_err          (mem_err),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt),
        .memwait_cnt      (memwait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit frz_if;
        bit fl_if;
        bit fl_id;
        bit frz_all;
        bit err;
        int stall;
        int flush;
        int mw;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state: are we waiting on memory, how many cycles have
    // been spent waiting so far, sticky error, and event tallies.
    bit m_waiting;
    int m_waited;
    bit m_err;
    int m_stall, m_flush, m_mw;

    function automatic bit needs(input logic [REG_W-1:0] d);
        return (use_src1_ID && src1_ID == d) || (two_src_ID && src2_ID == d);
    endfunction

    function automatic int bump(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    // Predict this cycle from the inputs already applied, then advance the
    // model across the coming rising edge.
    task automatic step();
        exp_t e;
        bit hz, tmo, stall, br, hz_only;
        bit rst_v, clr_v, req_v, rdy_v;
        if (!rst) begin
            m_waiting = 0; m_waited = 0; m_err = 0;
            m_stall = 0; m_flush = 0; m_mw = 0;
        end
        if (forward_en) hz = mem_r_en_EXE && wb_en_EXE && needs(dest_EXE);
        else            hz = (wb_en_EXE && needs(dest_EXE)) || (wb_en_MEM && needs(dest_MEM));
        // This is the TO-th cycle spent waiting and memory is still busy.
        tmo     = m_waiting && !mem_ready && (m_waited + 1 >= TO);
        stall   = m_waiting ? (!mem_ready && !tmo) : (mem_req_MEM && !mem_ready);
        br      = branch_taken_EXE && !stall;
        hz_only = hz && !stall && !branch_taken_EXE;
        e.frz_if  = stall || hz_only;
        e.fl_if   = br;
        e.fl_id   = br || hz_only;
        e.frz_all = stall;
        e.err     = m_err;
        e.stall   = m_stall;
        e.flush   = m_flush;
        e.mw      = m_mw;
        sb_q.push_back(e);
        rst_v = rst; clr_v = clr_stats; req_v = mem_req_MEM; rdy_v = mem_ready;
        @(posedge clk);
        if (rst_v) begin
            if (clr_v) begin
                m_stall = 0; m_flush = 0; m_mw = 0; m_err = 0;
            end else begin
                if (hz_only) m_stall = bump(m_stall);
                if (br)      m_flush = bump(m_flush);
                if (stall)   m_mw    = bump(m_mw);
                if (tmo)     m_err   = 1;
            end
            if (m_waiting) begin
                if (rdy_v || tmo) begin m_waiting = 0; m_waited = 0; end
                else m_waited++;
            end else if (req_v && !rdy_v) begin
                m_waiting = 1; m_waited = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        src1_ID = '0; src2_ID = '0; dest_EXE = '0; dest_MEM = '0;
        use_src1_ID = 0; two_src_ID = 0; wb_en_EXE = 0; wb_en_MEM = 0;
        mem_r_en_EXE = 0; forward_en = 0; branch_taken_EXE = 0;
        mem_req_MEM = 0; mem_ready = 0; clr_stats = 0;
    endtask

    task automatic check(input string nm, input int act, input int exp_v, inout bit bad);
        if (act != exp_v) begin
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp_v);
            bad = 1;
        end
    endtask

    // Monitor: compare each predicted cycle against the DUT well before the
    // next rising edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   bad;
        #2;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            bad = 0;
            check("freeze_IF",   int'(freeze_IF),   int'(e.frz_if),  bad);
            check("flush_IF",    int'(flush_IF),    int'(e.fl_if),   bad);
            check("flush_ID",    int'(flush_ID),    int'(e.fl_id),   bad);
            check("freeze_all",  int'(freeze_all),  int'(e.frz_all), bad);
            check("mem_err",     int'(mem_err),     int'(e.err),     bad);
            check("stall_cnt",   int'(stall_cnt),   e.stall,         bad);
            check("flush_cnt",   int'(flush_cnt),   e.flush,         bad);
            check("memwait_cnt", int'(memwait_cnt), e.mw,            bad);
            n_vec++;
            if (bad) n_bad++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        idle();
        rst = 1'b0;
        m_waiting = 0; m_waited = 0; m_err = 0;
        m_stall = 0; m_flush = 0; m_mw = 0;
        @(negedge clk);

        // Reset state, then release.
        repeat (2) step();
        rst = 1'b1;
        step();

        // Hazard against a MEM-stage writer without forwarding.
        forward_en = 0; src1_ID = 4'd3; use_src1_ID = 1; dest_MEM = 4'd3; wb_en_MEM = 1;
        step();
        idle(); step();

        // With forwarding, an ALU producer in EXE is bypassed; a load is not.
        forward_en = 1; dest_EXE = 4'd5; wb_en_EXE = 1; src2_ID = 4'd5; two_src_ID = 1;
        mem_r_en_EXE = 0; step();
        mem_r_en_EXE = 1; step();

        // Hazard and taken branch together: branch wins.
        branch_taken_EXE = 1; step();
        idle(); step();

        // Memory stall for three cycles with a branch held in EXE.
        mem_req_MEM = 1; mem_ready = 0; branch_taken_EXE = 1;
        repeat (3) step();
        mem_ready = 1; step();
        idle(); step();

        // Memory never answers: timeout, release, sticky error, then clear.
        mem_req_MEM = 1; mem_ready = 0;
        repeat (5) step();
        mem_req_MEM = 0;
        repeat (5) step();
        clr_stats = 1; step();
        clr_stats = 0; step();

        // Saturation of stall_cnt, then reset in the middle of a wait.
        forward_en = 0; src1_ID = 4'd7; use_src1_ID = 1; dest_EXE = 4'd7; wb_en_EXE = 1;
        repeat (20) step();
        idle();
        mem_req_MEM = 1; mem_ready = 0;
        repeat (3) step();
        rst = 0; step();
        mem_req_MEM = 0; step();
        rst = 1; step();

        // Random traffic with small register ranges so matches are common.
        for (int i = 0; i < 600; i++) begin
            src1_ID          = REG_W'($urandom_range(0, 3));
            src2_ID          = REG_W'($urandom_range(0, 3));
            dest_EXE         = REG_W'($urandom_range(0, 3));
            dest_MEM         = REG_W'($urandom_range(0, 3));
            use_src1_ID      = 1'($urandom_range(0, 1));
            two_src_ID       = 1'($urandom_range(0, 1));
            wb_en_EXE        = 1'($urandom_range(0, 1));
            wb_en_MEM        = 1'($urandom_range(0, 1));
            mem_r_en_EXE     = 1'($urandom_range(0, 1));
            forward_en       = 1'($urandom_range(0, 1));
            branch_taken_EXE = ($urandom_range(0, 4) == 0);
            mem_req_MEM      = ($urandom_range(0, 2) == 0);
            mem_ready        = ($urandom_range(0, 2) == 0);
            clr_stats        = ($urandom_range(0, 39) == 0);
            rst              = !($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1; idle(); step();

        @(negedge clk);
        #4;
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
            n_bad++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 4, register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 64, max MEM_WAIT cycles before error.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 src1_ID, src2_ID  in  REG_W  ID-stage source register indices.
REQ-007 use_src1_ID, two_src_ID  in  1  src1 valid / src2 valid.
REQ-008 dest_EXE, dest_MEM  in  REG_W  destination indices in EXE / MEM.
REQ-009 wb_en_EXE, wb_en_MEM  in  1  writeback enables in EXE / MEM.
REQ-010 mem_r_en_EXE  in  1  EXE instruction is a load.
REQ-011 forward_en  in  1  forwarding unit active.
REQ-012 branch_taken_EXE  in  1  branch resolved taken in EXE.
REQ-013 mem_req_MEM  in  1  MEM stage memory access; mem_ready  in  1  memory done this cycle.
REQ-014 clr_stats  in  1  synchronous statistics clear pulse.
REQ-015 freeze_IF  out  1  hold PC and IF/ID register; flush_IF  out  1  zero IF/ID register.
REQ-016 flush_ID  out  1  bubble into ID/EXE; freeze_all  out  1  hold ID/EXE, EXE/MEM, MEM/WB.
REQ-017 mem_err  out  1  sticky timeout flag.
REQ-018 stall_cnt, flush_cnt, memwait_cnt  out  CNT_W  statistics counters.

Function
REQ-019 SHALL compute control outputs combinationally from inputs and current state (zero-cycle latency).
REQ-020 hazard (forward_en=0): wb_en_EXE and match to dest_EXE, or wb_en_MEM and match to dest_MEM; match = (use_src1_ID and src1==dest) or (two_src_ID and src2==dest).
REQ-021 hazard (forward_en=1): only mem_r_en_EXE and wb_en_EXE and match to dest_EXE (load-use).
REQ-022 FSM states RUN, MEM_WAIT; RUN->MEM_WAIT when mem_req_MEM and not mem_ready; MEM_WAIT->RUN when mem_ready or timeout.
REQ-023 mem_stall = (mem_req_MEM and not mem_ready) in RUN, (not mem_ready) in MEM_WAIT; mem_req_MEM with mem_ready same cycle: no stall, stay RUN.
REQ-024 priority mem_stall > branch > hazard.
REQ-025 mem_stall: freeze_all=1, freeze_IF=1, flush_IF=0, flush_ID=0; a taken branch held in EXE is deferred until release.
REQ-026 branch (no mem_stall): flush_IF=1, flush_ID=1, freeze_IF=0 (IF/ID register gives freeze priority over flush, so freeze_IF must be low).
REQ-027 hazard only: freeze_IF=1, flush_ID=1, flush_IF=0, freeze_all=0.
REQ-028 otherwise all control outputs 0.
REQ-029 wait counter counts MEM_WAIT cycles; counter reaching MEM_TIMEOUT with mem_ready low: set mem_err, return to RUN, release freeze that cycle; cleared on RUN entry.
REQ-030 mem_err sticky until reset or clr_stats.
REQ-031 stall_cnt +1 per hazard-only cycle; flush_cnt +1 per branch-flush cycle; memwait_cnt +1 per mem_stall cycle.
REQ-032 counters saturate at all-ones, no wrap; clr_stats zeroes all counters and mem_err, wins over same-cycle increment.

Reset
REQ-033 rst low asynchronously forces state RUN, wait counter 0, mem_err 0, all statistics counters 0.
REQ-034 during reset, combinational outputs follow REQ-020..028 with state RUN; mid-MEM_WAIT reset abandons wait immediately.

Structure
REQ-035 shared package holds FSM state enum (RUN, MEM_WAIT) and default REG_W/CNT_W.
REQ-036 one sub-module sat_counter (CNT_W, inc, clr) instantiated three times; hazard compare and FSM inline.

Verification
REQ-037 forward_en=0, src1_ID=3, use_src1_ID=1, dest_MEM=3, wb_en_MEM=1 -> freeze_IF=1, flush_ID=1, stall_cnt 0->1.
REQ-038 forward_en=1, dest_EXE=5, wb_en_EXE=1, mem_r_en_EXE=0, src2_ID=5, two_src_ID=1 -> no stall; set mem_r_en_EXE=1 -> freeze_IF=1, flush_ID=1.
REQ-039 hazard and branch_taken_EXE same cycle -> flush_IF=1, flush_ID=1, freeze_IF=0, flush_cnt +1, stall_cnt unchanged.
REQ-040 mem_req_MEM=1, mem_ready low 3 cycles with branch_taken_EXE=1 -> freeze_all=1 three cycles, no flush, memwait_cnt=3; mem_ready=1 -> RUN, flush next unfrozen cycle.
REQ-041 MEM_TIMEOUT=4, mem_ready never -> mem_err=1 after 4 MEM_WAIT cycles, freeze released, clr_stats -> mem_err=0, counters 0.
REQ-042 CNT_W=4, 20 hazard cycles -> stall_cnt holds 15; rst low mid-MEM_WAIT -> all counters 0, freeze_all follows mem_stall of RUN.
